// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, variable-latency unified memory between the IF
// stage (instruction fetch, read-only) and the MEM stage (load/store) of a
// 5-stage pipeline. Each stage access is sequenced through the memory
// request/ack handshake and its result is held until the pipeline advances.
// A single global stall freezes the pipeline until every pending stage access
// has completed.
//
// Handshake contract (memory side):
//   mem_req_o is held high, with mem_we_o/mem_addr_o/mem_wdata_o stable, for
//   the whole BUSY phase. The memory answers with a one-cycle mem_ack_i pulse,
//   with mem_rdata_i valid in that same cycle. The request drops on the edge
//   that samples the ack. An ack seen while no request is outstanding is
//   ignored. Stage side: a stage request is "pending" while it is asserted and
//   its valid flag is clear; stall_o is high while anything is pending or the
//   memory is busy, and the stage holds address/data stable while stalled.
//
// Ports:
//   clk_i, rst_i              clock (rising edge), synchronous active-low reset
//   if_req_i, if_addr_i       fetch request / PC
//   if_rdata_o, if_valid_o    fetched instruction, held for current cycle
//   dm_rd_i, dm_wr_i          load / store request (both high = store)
//   dm_addr_i, dm_wdata_i     data address / store data
//   dm_rdata_o, dm_valid_o    load data (0 on stores), held for current cycle
//   stall_o                   global pipeline stall (combinational)
//   mem_req_o, mem_we_o       memory request / write enable
//   mem_addr_o, mem_wdata_o   memory address / write data
//   mem_ack_i, mem_rdata_i    memory completion pulse / read data
//   err_o                     sticky watchdog timeout flag
//   dbg_state_o               current FSM state (0 IDLE, 1 BUSY_I, 2 BUSY_D)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // IF stage
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_valid_o,
  // MEM stage
  input  logic          dm_rd_i,
  input  logic          dm_wr_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic [DW-1:0] dm_rdata_o,
  output logic          dm_valid_o,
  // pipeline control
  output logic          stall_o,
  // unified memory
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i,
  // status / debug
  output logic          err_o,
  output logic [1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  // Watchdog: the counter holds the number of BUSY cycles already spent
  // without an ack, so the transaction is cut on the TIMEOUT-th BUSY cycle.
  localparam bit          LP_WD_EN   = (TIMEOUT > 0);
  localparam logic [15:0] LP_TO_LAST = LP_WD_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_t        r_state;
  logic [15:0]   r_to_cnt;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_if_rdata;
  logic          r_if_valid;
  logic [DW-1:0] r_dm_rdata;
  logic          r_dm_valid;
  logic          r_err;

  logic          w_dm_acc;
  logic          w_if_pend;
  logic          w_dm_pend;
  logic          w_stall;
  logic          w_busy;
  logic          w_timeout;
  logic          w_cpl;
  logic [DW-1:0] w_cpl_data;

  assign w_dm_acc  = dm_rd_i | dm_wr_i;
  // A stage whose result is already held is not pending: this is what
  // prevents a completed access from being issued a second time.
  assign w_if_pend = if_req_i & ~r_if_valid;
  assign w_dm_pend = w_dm_acc & ~r_dm_valid;
  assign w_busy    = (r_state != ST_IDLE);
  assign w_stall   = w_if_pend | w_dm_pend | w_busy;

  // An ack in the timeout cycle wins: normal completion with real data.
  assign w_timeout  = LP_WD_EN & (r_to_cnt == LP_TO_LAST);
  assign w_cpl      = mem_ack_i | w_timeout;
  assign w_cpl_data = mem_ack_i ? mem_rdata_i : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= ST_IDLE;
      r_to_cnt    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_dm_rdata  <= '0;
      r_dm_valid  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Pipeline advances on a non-stall edge: held results are consumed.
      // While stalled they persist, so a finished fetch survives a slow load.
      if (!w_stall) begin
        r_if_valid <= 1'b0;
        r_dm_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_to_cnt <= '0;
          // Data first: the MEM-stage instruction is older than the fetch.
          if (w_dm_pend) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= dm_wr_i;
            r_mem_addr  <= dm_addr_i;
            r_mem_wdata <= dm_wdata_i;
            r_state     <= ST_BUSY_D;
          end else if (w_if_pend) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr_i;
            r_mem_wdata <= '0;
            r_state     <= ST_BUSY_I;
          end
        end

        ST_BUSY_I, ST_BUSY_D: begin
          if (w_cpl) begin
            if (r_state == ST_BUSY_I) begin
              r_if_rdata <= w_cpl_data;
              r_if_valid <= 1'b1;
            end else begin
              // Stores return no data; keep the load result at zero.
              r_dm_rdata <= r_mem_we ? '0 : w_cpl_data;
              r_dm_valid <= 1'b1;
            end
            if (!mem_ack_i) begin
              r_err <= 1'b1;
            end
            r_mem_req <= 1'b0;
            r_to_cnt  <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
        end

        default: begin
          r_mem_req <= 1'b0;
          r_to_cnt  <= '0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall_o     = w_stall;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign if_rdata_o  = r_if_rdata;
  assign if_valid_o  = r_if_valid;
  assign dm_rdata_o  = r_dm_rdata;
  assign dm_valid_o  = r_dm_valid;
  assign err_o       = r_err;
  assign dbg_state_o = r_state;

endmodule
